// File: rtl/mem_writer.sv
// mem_writer: range-checks a base/length request, then writes each accepted stream word
// to consecutive RAM addresses through registered write strobes.
module mem_writer #(
   parameter int bits = 8,
   parameter int size = 16,
   parameter int address_size = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [address_size-1:0] base_addr,
   input  logic [address_size:0]   length,
   input  logic                    in_valid,
   input  logic [bits-1:0]         in_data,
   output logic                    in_ready,
   output logic                    mem_we,
   output logic [address_size-1:0] mem_address,
   output logic [bits-1:0]         mem_dataIn,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   state_t state, nxt;
   logic [address_size-1:0] base_q;
   logic [address_size:0]   len_q, cnt;
   logic [address_size+1:0] end_addr;
   logic over, hs, last, accept;
   // two extra bits keep base+length from overflowing before the compare against size
   assign end_addr = {2'b0, base_addr} + {1'b0, length};
   assign over     = end_addr > (address_size+2)'(size);
   assign in_ready = state == WRITE;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign hs       = in_valid && in_ready;
   assign last     = cnt == len_q - 1'b1;
   assign accept   = state == IDLE && start && !over;
   always_comb begin
      nxt = state;
      nxt = state == IDLE  ? (accept ? (length == '0 ? DONE : WRITE) : IDLE) :
            state == WRITE ? (hs && last ? DONE : WRITE) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_dataIn  <= '0;
         error       <= 1'b0;
         cnt         <= '0;
         base_q      <= '0;
         len_q       <= '0;
      end else begin
         state  <= nxt;
         mem_we <= hs;
         error  <= state == IDLE && start && over;
         if (accept && length != '0) begin
            base_q <= base_addr;
            len_q  <= length;
            cnt    <= '0;
         end
         if (hs) begin
            mem_address <= base_q + cnt[address_size-1:0];
            mem_dataIn  <= in_data;
            cnt         <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_writer.sv
// tb_mem_writer: scoreboard bench for mem_writer; expected writes are queued at each handshake.
module tb_mem_writer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [3:0] base_addr = '0;
   logic [4:0] length = '0;
   logic [7:0] in_data = '0;
   logic in_ready, mem_we, busy, done, error;
   logic [3:0] mem_address;
   logic [7:0] mem_dataIn;
   logic [11:0] sb[$];
   int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;

   mem_writer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
      .mem_address(mem_address), .mem_dataIn(mem_dataIn), .busy(busy), .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) n_done++;
      if (error) n_err++;
      if (mem_we) begin
         if (sb.size() == 0) check("we_unexpected", {28'd0, mem_address}, 32'hFFFF);
         else begin
            logic [11:0] e;
            e = sb.pop_front();
            check("wr_addr", {28'd0, mem_address}, {28'd0, e[11:8]});
            check("wr_data", {24'd0, mem_dataIn}, {24'd0, e[7:0]});
         end
      end
   end

   task step();
      @(posedge clk);
      #1;
   endtask

   task req(input logic [3:0] b, input logic [4:0] l);
      start = 1'b1; base_addr = b; length = l;
      step();
      start = 1'b0;
   endtask

   task send(input logic [7:0] d, input logic [3:0] a);
      int t;
      t = 0;
      in_valid = 1'b1; in_data = d;
      while (!in_ready && t < 20) begin
         step();
         t++;
      end
      if (t == 20) check("ready_timeout", 0, 1);
      else sb.push_back({a, d});
      step();
      in_valid = 1'b0;
      check("we_latency", {31'd0, mem_we}, 1);
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check("rst_we", {31'd0, mem_we}, 0);
      check("rst_addr", {28'd0, mem_address}, 0);
      check("rst_data", {24'd0, mem_dataIn}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_error", {31'd0, error}, 0);
      check("rst_ready", {31'd0, in_ready}, 0);
      // 1: full window, continuous stream
      req(4'd0, 5'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < 15) check("t1_not_done", {31'd0, done}, 0);
         send(8'hA0 + 8'(i), 4'(i));
      end
      check("t1_done", {31'd0, done}, 1);
      check("t1_ready_done", {31'd0, in_ready}, 0);
      step();
      check("t1_idle_busy", {31'd0, busy}, 0);
      check("t1_idle_ready", {31'd0, in_ready}, 0);
      check("t1_idle_done", {31'd0, done}, 0);
      // 2: stalled source
      req(4'd5, 5'd3);
      send(8'h11, 4'd5);
      step();
      check("t2_stall_we", {31'd0, mem_we}, 0);
      send(8'h22, 4'd6);
      step();
      check("t2_stall_we", {31'd0, mem_we}, 0);
      send(8'h33, 4'd7);
      check("t2_done", {31'd0, done}, 1);
      step();
      // 3: out of range, then the largest legal window at the top
      req(4'd14, 5'd3);
      check("t3_error", {31'd0, error}, 1);
      check("t3_busy", {31'd0, busy}, 0);
      check("t3_ready", {31'd0, in_ready}, 0);
      check("t3_we", {31'd0, mem_we}, 0);
      step();
      check("t3_error_pulse", {31'd0, error}, 0);
      check("t3_busy2", {31'd0, busy}, 0);
      req(4'd14, 5'd2);
      check("t3_ok_error", {31'd0, error}, 0);
      send(8'h5A, 4'd14);
      send(8'hA5, 4'd15);
      check("t3_done", {31'd0, done}, 1);
      step();
      // 4: zero length
      req(4'd3, 5'd0);
      check("t4_busy", {31'd0, busy}, 1);
      check("t4_done", {31'd0, done}, 1);
      check("t4_we", {31'd0, mem_we}, 0);
      check("t4_ready", {31'd0, in_ready}, 0);
      step();
      check("t4_idle", {31'd0, busy}, 0);
      check("t4_done_pulse", {31'd0, done}, 0);
      // 5: reset mid-transfer
      req(4'd0, 5'd8);
      send(8'h01, 4'd0);
      send(8'h02, 4'd1);
      send(8'h03, 4'd2);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("t5_we", {31'd0, mem_we}, 0);
      check("t5_busy", {31'd0, busy}, 0);
      check("t5_done", {31'd0, done}, 0);
      step();
      check("t5_we2", {31'd0, mem_we}, 0);
      req(4'd8, 5'd2);
      send(8'h81, 4'd8);
      send(8'h82, 4'd9);
      check("t5_done2", {31'd0, done}, 1);
      step();
      // 6: start during WRITE and DONE is ignored
      req(4'd2, 5'd4);
      send(8'hC2, 4'd2);
      start = 1'b1; base_addr = 4'd9; length = 5'd1;
      send(8'hC3, 4'd3);
      send(8'hC4, 4'd4);
      start = 1'b0;
      send(8'hC5, 4'd5);
      check("t6_done", {31'd0, done}, 1);
      start = 1'b1; base_addr = 4'd0; length = 5'd1;
      step();
      start = 1'b0;
      check("t6_no_restart", {31'd0, busy}, 0);
      check("t6_no_ready", {31'd0, in_ready}, 0);
      step();
      check("t6_still_idle", {31'd0, busy}, 0);
      step();
      check("sb_empty", sb.size(), 0);
      check("done_pulses", n_done, 6);
      check("error_pulses", n_err, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
- Write-side companion to the team's synchronous single-port RAM: fills a contiguous address window with a stream of words.
- A control master programs a base address and word count, then pulses start.
- Words arrive on a valid/ready stream and are issued as registered RAM write strobes (mem_we/mem_address/mem_dataIn) at consecutive addresses.
- Sits between the data source and the RAM write port; reports completion and out-of-range requests.

Parameters:
bits, 8, RAM word width
size, 16, number of RAM words (need not be a power of two)
address_size, 4, RAM address width; ceil(log2(size)) <= address_size

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a transfer
base_addr  input  address_size  first RAM address written
length  input  address_size+1  number of words to write, 0..size
in_valid  input  1  stream word available
in_data  input  bits  stream word
in_ready  output  1  block accepts a stream word this cycle
mem_we  output  1  RAM write enable (registered)
mem_address  output  address_size  RAM address (registered)
mem_dataIn  output  bits  RAM write data (registered)
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse: request rejected as out of range

Behaviour:
- States: IDLE, WRITE, DONE. The state register and all registered outputs update only on the clk rising edge.
- Reset (rst=1 at an edge): state=IDLE; mem_we=0, mem_address=0, mem_dataIn=0, done=0, error=0; word counter=0; latched base/length=0.
  - Reset mid-transfer aborts with no further write. Any write strobe already registered is cleared in the reset cycle.
- in_ready = (state==WRITE), combinational from state only. busy = (state!=IDLE).
- IDLE, start=1, range check done in address_size+2 bit arithmetic:
  - base_addr+length > size: error=1 for the next cycle, state stays IDLE, nothing is latched.
  - length==0: go to DONE (done=1 next cycle, no write).
  - Otherwise: latch base_addr and length, clear counter, go to WRITE.
- start is ignored when not IDLE. start and rst together: rst wins.
- WRITE: a handshake occurs on a cycle with in_valid=1 and in_ready=1. A handshake at edge N gives, at cycle N+1:
  - mem_we=1
  - mem_address = latched base + counter (counter value before increment)
  - mem_dataIn = in_data
  - counter incremented
- Cycles without a handshake produce mem_we=0 at N+1. mem_address and mem_dataIn hold their last values.
- Handshake on the word where counter==length-1: next state DONE.
- DONE lasts exactly one cycle, with done=1 and busy=1.
  - For length>=1, the final mem_we=1 coincides with the DONE cycle.
  - in_ready=0 in DONE. The next state is IDLE.
- A start in the DONE cycle is ignored; start is accepted again from the following IDLE cycle.
- Addresses never wrap, because the range check guarantees base+length <= size. The maximum address written is size-1.
- Back-to-back handshakes give one write per cycle (full throughput). The source may stall arbitrarily.
- in_data is not sampled outside handshake cycles.

Test Plan:
1. rst, then start with base=0, length=16, in_valid held high, in_data=16'd... 0xA0+i. Required: mem_we high for 16 consecutive cycles, addresses 0..15, data 0xA0..0xAF; done pulses once on the 16th write cycle; in_ready low afterwards.
2. base=5, length=3, in_valid toggling 1,0,1,0,1 with data 0x11,0x22,0x33. Required: writes 0x11@5, 0x22@6, 0x33@7, each exactly one cycle after its handshake; mem_we=0 in stall cycles; done with the write to 7.
3. base=14, length=3 (14+3>16). Required: error=1 for one cycle, busy stays 0, no mem_we, in_ready stays 0. Then base=14, length=2 is accepted and writes addresses 14 and 15.
4. length=0, base=3. Required: busy=1 and done=1 for one cycle, no mem_we, back to IDLE.
5. base=0, length=8; assert rst after the 3rd handshake. Required: mem_we=0, busy=0, done=0 in the cycle after reset; no write to address 3 or above. A new start with base=8, length=2 then operates normally.
6. start pulsed during WRITE and during DONE. Required: no relatch, the transfer completes with its original base/length, and exactly one done pulse.
